// File: rtl/four_bit_full_adder_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master drives operands and reads results; the slave is the adder itself.
interface four_bit_full_adder_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic [WIDTH-1:0] S;
   logic             Cout;
   logic             overflow;
   logic             out_valid;

   modport master (
      output in_valid, A, B, Cin,
      input  S, Cout, overflow, out_valid
   );

   modport slave (
      input  in_valid, A, B, Cin,
      output S, Cout, overflow, out_valid
   );
endinterface

// File: rtl/four_bit_full_adder.sv
// Registered ripple-carry adder: {Cout,S} = A + B + Cin with a signed-overflow flag,
// built from half-adder based full-adder cells, one cycle of latency.
module fa_half_adder (
   input  logic i_a,
   input  logic i_b,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b;
   assign o_c = i_a & i_b;
endmodule

module fa_full_adder_cell (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);
   logic w_s1;
   logic w_c1;
   logic w_c2;

   fa_half_adder u_ha1 (
      .i_a (i_a),
      .i_b (i_b),
      .o_s (w_s1),
      .o_c (w_c1)
   );

   fa_half_adder u_ha2 (
      .i_a (w_s1),
      .i_b (i_cin),
      .o_s (o_sum),
      .o_c (w_c2)
   );

   assign o_cout = w_c1 | w_c2;
endmodule

module four_bit_full_adder #(
   parameter int WIDTH = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   four_bit_full_adder_if.slave bus
);
   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic             w_overflow;

   logic [WIDTH-1:0] r_s;
   logic             r_cout;
   logic             r_overflow;
   logic             r_out_valid;

   assign w_carry[0] = bus.Cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      fa_full_adder_cell u_cell (
         .i_a    (bus.A[i]),
         .i_b    (bus.B[i]),
         .i_cin  (w_carry[i]),
         .o_sum  (w_sum[i]),
         .o_cout (w_carry[i+1])
      );
   end

   // Signed overflow: carry into the sign cell differs from carry out of it.
   assign w_cout     = w_carry[WIDTH];
   assign w_overflow = w_carry[WIDTH-1] ^ w_carry[WIDTH];

   // NOTE: reset is sampled on the clock edge (synchronous), and all state uses
   // non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s         <= '0;
         r_cout      <= 1'b0;
         r_overflow  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_s        <= w_sum;
            r_cout     <= w_cout;
            r_overflow <= w_overflow;
         end
      end
   end

   assign bus.S         = r_s;
   assign bus.Cout      = r_cout;
   assign bus.overflow  = r_overflow;
   assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_four_bit_full_adder.sv
// Self-checking bench for four_bit_full_adder: directed table, reset/hold sequences,
// exhaustive sweep and randomized traffic against an arithmetic reference model.
module tb_four_bit_full_adder;
   localparam int WIDTH = 4;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic [3:0] s;
      logic       cout;
      logic       ovf;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;
   // {overflow, Cout, S} the outputs should currently hold
   logic [5:0] last_res;

   four_bit_full_adder_if #(.WIDTH(WIDTH)) bus ();

   four_bit_full_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   function automatic logic [7:0] observed();
      return {1'b0, bus.out_valid, bus.overflow, bus.Cout, bus.S};
   endfunction

   // Reference: {ovf, cout, s} from integer arithmetic on the operands.
   function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic cin);
      int          u_total;
      int          s_total;
      logic [4:0]  u5;
      logic        ovf;
      u_total = int'(a) + int'(b) + int'(cin);
      s_total = (a[3] ? int'(a) - 16 : int'(a)) + (b[3] ? int'(b) - 16 : int'(b)) + int'(cin);
      u5      = u_total[4:0];
      ovf     = (s_total > 7) || (s_total < -8);
      return {ovf, u5};
   endfunction

   task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic cin);
      bus.in_valid = v;
      bus.A        = a;
      bus.B        = b;
      bus.Cin      = cin;
   endtask

   // One clock with the given operands, then compare against the model / held value.
   task automatic step(input string name, input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic cin);
      drive(v, a, b, cin);
      @(posedge clk);
      #1;
      if (v) last_res = model(a, b, cin);
      check(name, observed(), {1'b0, v, last_res});
   endtask

   vec_t dir_vecs[7];

   initial begin
      n_cmp    = 0;
      n_fail   = 0;
      last_res = '0;

      dir_vecs[0] = '{a: 4'b0000, b: 4'b0000, cin: 1'b0, s: 4'b0000, cout: 1'b0, ovf: 1'b0};
      dir_vecs[1] = '{a: 4'b1010, b: 4'b0101, cin: 1'b0, s: 4'b1111, cout: 1'b0, ovf: 1'b0};
      dir_vecs[2] = '{a: 4'b1111, b: 4'b1111, cin: 1'b0, s: 4'b1110, cout: 1'b1, ovf: 1'b0};
      dir_vecs[3] = '{a: 4'b1001, b: 4'b0110, cin: 1'b0, s: 4'b1111, cout: 1'b0, ovf: 1'b0};
      dir_vecs[4] = '{a: 4'b1111, b: 4'b0000, cin: 1'b1, s: 4'b0000, cout: 1'b1, ovf: 1'b0};
      dir_vecs[5] = '{a: 4'b0111, b: 4'b0001, cin: 1'b0, s: 4'b1000, cout: 1'b0, ovf: 1'b1};
      dir_vecs[6] = '{a: 4'b1000, b: 4'b1000, cin: 1'b0, s: 4'b0000, cout: 1'b1, ovf: 1'b1};

      // Reset held for two cycles while valid operands are presented.
      rst_n = 1'b0;
      drive(1'b1, 4'b1111, 4'b1111, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check("reset_hold", observed(), 8'h00);
      end

      // First result appears one cycle after release.
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_first", observed(), {1'b0, 1'b1, 1'b0, 1'b1, 4'b1110});
      last_res = {1'b0, 1'b1, 4'b1110};

      // Directed table streamed back-to-back.
      foreach (dir_vecs[i]) begin
         drive(1'b1, dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].cin);
         @(posedge clk);
         #1;
         check($sformatf("dir_%0d", i), observed(),
               {1'b0, 1'b1, dir_vecs[i].ovf, dir_vecs[i].cout, dir_vecs[i].s});
         last_res = {dir_vecs[i].ovf, dir_vecs[i].cout, dir_vecs[i].s};
      end

      // Hold: result persists while in_valid is low and operands wander.
      drive(1'b1, 4'b0011, 4'b0100, 1'b0);
      @(posedge clk);
      #1;
      check("hold_load", observed(), {1'b0, 1'b1, 1'b0, 1'b0, 4'b0111});
      last_res = {1'b0, 1'b0, 4'b0111};
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 4'(4'hF - i), 4'(4'h9 + i), 1'b1);
         @(posedge clk);
         #1;
         check($sformatf("hold_%0d", i), observed(), {1'b0, 1'b0, 1'b0, 1'b0, 4'b0111});
      end

      // Reset in the same cycle as a valid transaction discards it.
      rst_n = 1'b0;
      drive(1'b1, 4'b1111, 4'b1111, 1'b0);
      @(posedge clk);
      #1;
      check("midstream_reset", observed(), 8'h00);
      last_res = '0;
      rst_n = 1'b1;
      drive(1'b1, 4'b0001, 4'b0001, 1'b0);
      @(posedge clk);
      #1;
      check("after_reset_sum", observed(), {1'b0, 1'b1, 1'b0, 1'b0, 4'b0010});
      last_res = {1'b0, 1'b0, 4'b0010};

      // Exhaustive sweep, back-to-back.
      for (int v = 0; v < 512; v++) begin
         logic [8:0] op;
         op = 9'(v);
         step("exhaustive", 1'b1, op[8:5], op[4:1], op[0]);
      end

      // Randomized traffic with gaps.
      for (int i = 0; i < 400; i++) begin
         step("random", 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
